// File: rtl/mrl_pkg.sv
// Shared types and default widths for the memory-to-register block-copy engine.
package mrl_pkg;

    localparam int MRL_DATA_W = 32;
    localparam int MRL_MEM_AW = 6;
    localparam int MRL_REG_AW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mrl_state_t;

endpackage

// File: rtl/mrl_wr_stage.sv
// Write stage of the copy engine: delays the write-valid flag and the destination
// register address by one cycle so they line up with the RAM read data.
module mrl_wr_stage
    import mrl_pkg::*;
#(
    parameter int REG_AW = MRL_REG_AW
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              rd_valid,
    input  logic [REG_AW-1:0] rd_reg_addr,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_reg_addr
);

    // One-cycle delay matching the RAM read latency; the address holds between copies
    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_valid    <= 1'b0;
            wr_reg_addr <= '0;
        end else begin
            wr_valid <= rd_valid;
            if (rd_valid) begin
                wr_reg_addr <= rd_reg_addr;
            end
        end
    end

endmodule

// File: rtl/mem_reg_loader.sv
// Block-copy engine: reads N consecutive RAM words and writes them into consecutive
// register-file entries, one word per cycle, one cycle behind the RAM address.
// Optional feature: define MRL_CHECKSUM_EN to build the XOR checksum accumulator.
//
//   state | meaning
//   IDLE  | waiting for start; latches bases and count on accept
//   READ  | issuing one RAM address per cycle
//   DRAIN | last register write for the final address
//   DONE  | one-cycle completion pulse, start ignored
module mem_reg_loader
    import mrl_pkg::*;
#(
    parameter int DATA_W = MRL_DATA_W,
    parameter int MEM_AW = MRL_MEM_AW,
    parameter int REG_AW = MRL_REG_AW
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [MEM_AW-1:0] mem_base,
    input  logic [REG_AW-1:0] reg_base,
    input  logic [MEM_AW-1:0] count,
    output logic              busy,
    output logic              done,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] checksum
);

    mrl_state_t        state;
    mrl_state_t        next_state;
    logic              accept;
    logic              rd_valid;
    logic [REG_AW-1:0] reg_ptr;
    logic [MEM_AW-1:0] remaining;

    // State register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rd_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (count == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                if (remaining == MEM_AW'(1)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address pointers and remaining-word down-counter; mem_addr stays on the last
    // issued address so it only moves while reading
    always_ff @(posedge clk) begin
        if (Reset) begin
            mem_addr  <= '0;
            reg_ptr   <= '0;
            remaining <= '0;
        end else if (accept) begin
            reg_ptr   <= reg_base;
            remaining <= count;
            if (count != '0) begin
                mem_addr <= mem_base;
            end
        end else if (rd_valid) begin
            reg_ptr   <= reg_ptr + REG_AW'(1);
            remaining <= remaining - MEM_AW'(1);
            if (remaining != MEM_AW'(1)) begin
                mem_addr <= mem_addr + MEM_AW'(1);
            end
        end
    end

    mrl_wr_stage #(
        .REG_AW (REG_AW)
    ) u_wr_stage (
        .clk         (clk),
        .Reset       (Reset),
        .rd_valid    (rd_valid),
        .rd_reg_addr (reg_ptr),
        .wr_valid    (reg_we),
        .wr_reg_addr (reg_waddr)
    );

    assign mem_we    = 1'b0;
    assign reg_wdata = mem_rdata;

`ifdef MRL_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // XOR of every word written since the last accepted start
    always_ff @(posedge clk) begin
        if (Reset) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (reg_we) begin
            csum_q <= csum_q ^ mem_rdata;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_reg_loader.sv
// Self-checking bench for mem_reg_loader: behavioural RAM and register file around the
// DUT, expected register contents and timing derived from the copy rules.
module tb_mem_reg_loader;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [5:0]  mem_base;
    logic [4:0]  reg_base;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [31:0] checksum;

    logic [31:0] ram [64];
    logic [31:0] rf [32];
    logic [31:0] exp_rf [32];
    bit          exp_valid [32];
    logic [5:0]  exp_last_addr;

    int n_checks = 0;
    int n_errors = 0;

    mem_reg_loader dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .mem_base  (mem_base),
        .reg_base  (reg_base),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= ram[mem_addr];

    always @(posedge clk) begin
        if (reg_we === 1'b1) rf[reg_waddr] <= reg_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One copy, sampled at every falling edge. poke pulses start during busy and in the
    // DONE cycle; rst_cyc > 0 raises Reset in that cycle of the copy.
    task automatic run_copy(input int mb, input int rb, input int cnt, input bit poke, input int rst_cyc);
        int          last_cyc;
        int          nwr;
        int          hold_addr;
        logic [31:0] exp_csum;
        bit          exp_busy, exp_done, exp_we;

        last_cyc  = (cnt == 0) ? 1 : cnt + 2;
        hold_addr = (cnt == 0) ? int'(exp_last_addr) : (mb + cnt - 1) % 64;
        nwr       = cnt;
        if (rst_cyc > 0 && rst_cyc - 1 < cnt) nwr = rst_cyc - 1;

        @(negedge clk);
        start    = 1'b1;
        mem_base = 6'(mb);
        reg_base = 5'(rb);
        count    = 6'(cnt);
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 1; cyc <= last_cyc + 2; cyc++) begin
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_reg_we", reg_we, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_reg_waddr", reg_waddr, 0);
                check("rst_checksum", checksum, 0);
                Reset = 1'b0;
                for (int j = 0; j < 12; j++) begin
                    @(negedge clk);
                    check("post_rst_quiet", {busy, done, reg_we}, 0);
                end
                break;
            end
            exp_busy = (cnt > 0) && (cyc <= cnt + 1);
            exp_done = (cyc == last_cyc);
            exp_we   = (cnt > 0) && (cyc >= 2) && (cyc <= cnt + 1);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("reg_we", reg_we, exp_we);
            check("mem_we", mem_we, 0);
            if (cnt > 0 && cyc <= cnt) check("mem_addr", mem_addr, (mb + cyc - 1) % 64);
            else                       check("mem_addr_hold", mem_addr, hold_addr);
            if (exp_we) begin
                check("reg_waddr", reg_waddr, (rb + cyc - 2) % 32);
                check("reg_wdata", reg_wdata, ram[(mb + cyc - 2) % 64]);
            end
            start = 1'b0;
            if (poke && ((cyc == 2 && cnt > 0) || cyc == last_cyc)) begin
                start    = 1'b1;
                mem_base = 6'($urandom);
                reg_base = 5'($urandom);
                count    = 6'($urandom_range(1, 63));
            end
            if (rst_cyc > 0 && cyc == rst_cyc) Reset = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;

        exp_csum = '0;
        for (int k = 0; k < nwr; k++) begin
            exp_rf[(rb + k) % 32]    = ram[(mb + k) % 64];
            exp_valid[(rb + k) % 32] = 1'b1;
            exp_csum                 = exp_csum ^ ram[(mb + k) % 64];
        end
        if (rst_cyc > 0) begin
            exp_csum      = '0;
            exp_last_addr = '0;
        end else begin
            exp_last_addr = 6'(hold_addr);
        end
`ifndef MRL_CHECKSUM_EN
        exp_csum = '0;
`endif
        check("checksum", checksum, exp_csum);
        for (int r = 0; r < 32; r++) begin
            if (exp_valid[r]) check($sformatf("rf[%0d]", r), rf[r], exp_rf[r]);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        start    = 1'b0;
        mem_base = '0;
        reg_base = '0;
        count    = '0;
        exp_last_addr = '0;
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        for (int i = 0; i < 32; i++) exp_valid[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, reg_we}, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_reg_waddr", reg_waddr, 0);
        check("reset_checksum", checksum, 0);
        Reset = 1'b0;

        for (int i = 0; i < 4; i++) ram[10 + i] = 32'h1111_0001 + i;
        run_copy(10, 4, 4, 1'b0, 0);
        run_copy(20, 7, 0, 1'b0, 0);
        run_copy(62, 30, 4, 1'b0, 0);
        run_copy(5, 9, 6, 1'b1, 0);
        run_copy(30, 12, 8, 1'b0, 3);

        ram[40] = 32'h1234_5678;
        ram[41] = 32'h89AB_CDEF;
        run_copy(40, 0, 2, 1'b0, 0);
`ifdef MRL_CHECKSUM_EN
        check("checksum_example", checksum, 32'h9B9F_9B97);
`endif
        run_copy(3, 17, 63, 1'b1, 0);
        run_copy(1, 1, 1, 1'b1, 0);
        run_copy(8, 2, 0, 1'b1, 0);

        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < 8; i++) ram[$urandom_range(0, 63)] = $urandom;
            run_copy(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 40)), 1'($urandom), 0);
        end
        run_copy(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)), 20, 1'b0,
                 int'($urandom_range(2, 15)));
        run_copy(50, 25, 5, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
